// File: rtl/seg_pkg.sv
// seg_pkg: shared glyphs, conversion state encoding and sizing helper for the 7-segment scanner
package seg_pkg;
  localparam logic [9:0][6:0] GLYPHS = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [6:0] BLANK = 7'h00;
  localparam logic [6:0] DASH = 7'h40;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
  function automatic int ceil_log2(input int n);
    ceil_log2 = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) ceil_log2 = i + 1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter with a one-deep pending load
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int CW = ceil_log2(DATA_W);
  conv_state_t state;
  logic [DATA_W-1:0] bin, pend_val;
  logic pend_v;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] adj;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g+:4] = bcd[4*g+:4] >= 4'd5 ? bcd[4*g+:4] + 4'd3 : bcd[4*g+:4];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
      bin <= '0;
      pend_val <= '0;
      pend_v <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE) begin
        pend_v <= 1'b1;
        pend_val <= din;
      end
      case (state)
        IDLE: if (start) begin
          bin <= din;
          bcd <= '0;
          ovf <= 1'b0;
          cnt <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          // a one leaving the top nibble means the value needs more digits than we have
          bcd <= {adj[4*DIGITS-2:0], bin[DATA_W-1]};
          bin <= {bin[DATA_W-2:0], 1'b0};
          ovf <= ovf | adj[4*DIGITS-1];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) begin
            state <= COMMIT;
            done <= 1'b1;
          end
        end
        COMMIT: if (start || pend_v) begin
          bin <= start ? din : pend_val;
          bcd <= '0;
          ovf <= 1'b0;
          cnt <= '0;
          pend_v <= 1'b0;
          state <= SHIFT;
        end else begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with sequential BCD conversion, blanking, dp, blink and overflow dash
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int DATA_W = 16,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_TICKS = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] num,
  input  logic              num_valid,
  output logic              busy,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg_led
);
  localparam int IW = ceil_log2(DIGITS);
  localparam int SW = ceil_log2(SCAN_DIV);
  localparam int BW = ceil_log2(BLINK_TICKS);
  logic done, ovf, disp_ovf, phase, wrap, blink_last;
  logic [4*DIGITS-1:0] bcd, disp;
  logic [DIGITS-1:0] lz, sel_oh;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [IW-1:0] idx, idx_next;
  logic [3:0] dig;
  logic [6:0] glyph;
  logic [7:0] pat;
  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(num_valid), .din(num),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );
  // lz[i]: digits 0..i are all zero, i.e. digit i sits above the first nonzero digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_lz
    assign lz[g] = disp[4*DIGITS-1 -: 4*(g+1)] == '0;
  end
  always_comb begin
    wrap = scan_cnt == SW'(SCAN_DIV - 1);
    blink_last = blink_cnt == BW'(BLINK_TICKS - 1);
    idx_next = !wrap ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    sel_oh = DIGITS'(1) << idx_next;
    dig = disp[4*(DIGITS-1-int'(idx))+:4];
    glyph = disp_ovf ? DASH
          : (blank_lz && lz[idx] && idx != IW'(DIGITS - 1)) || dig > 4'd9 ? BLANK
          : GLYPHS[dig];
    pat = blink_en && phase ? 8'h00 : {dp_mask[idx], glyph};
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp <= '0;
      disp_ovf <= 1'b0;
      scan_cnt <= '0;
      idx <= '0;
      blink_cnt <= '0;
      phase <= 1'b0;
      seg_sel <= {DIGITS{SEL_ACTIVE_LOW}} ^ DIGITS'(1);
      seg_led <= {8{SEG_ACTIVE_LOW}};
    end else begin
      if (done) begin
        disp <= bcd;
        disp_ovf <= ovf;
      end
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      idx <= idx_next;
      if (!blink_en) begin
        blink_cnt <= '0;
        phase <= 1'b0;
      end else if (wrap) begin
        blink_cnt <= blink_last ? '0 : blink_cnt + 1'b1;
        phase <= phase ^ blink_last;
      end
      seg_sel <= {DIGITS{SEL_ACTIVE_LOW}} ^ sel_oh;
      seg_led <= {8{SEG_ACTIVE_LOW}} ^ pat;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized checks of two scanner instances (5 and 4 digits) against a decimal reference model
module tb_seg_scan_driver;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [15:0] num = '0;
  logic num_valid = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
  logic [4:0] dp5 = '0;
  logic [3:0] dp4 = '0;
  logic busy5, busy4;
  logic [4:0] sel5;
  logic [3:0] sel4;
  logic [7:0] led5, led4;
  int checks = 0, errors = 0;
  logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 sys_clk = ~sys_clk;

  seg_scan_driver #(.DIGITS(5), .DATA_W(16), .SCAN_DIV(4), .BLINK_TICKS(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .num(num), .num_valid(num_valid), .busy(busy5),
    .dp_mask(dp5), .blank_lz(blank_lz), .blink_en(blink_en), .seg_sel(sel5), .seg_led(led5));
  seg_scan_driver #(.DIGITS(4), .DATA_W(16), .SCAN_DIV(4), .BLINK_TICKS(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .num(num), .num_valid(num_valid), .busy(busy4),
    .dp_mask(dp4), .blank_lz(blank_lz), .blink_en(blink_en), .seg_sel(sel4), .seg_led(led4));

  // Reference: decimal digit i (0 = most significant) of v on an nd-digit display, active-low
  function automatic logic [7:0] exp_led(int v, int nd, bit lz, logic [7:0] dpm, int i);
    int p;
    logic [7:0] s;
    p = 10 ** (nd - 1 - i);
    if (v >= 10 ** nd) s = 8'hBF;
    else if (lz && i != nd - 1 && v < p) s = 8'hFF;
    else s = glyph_tab[(v / p) % 10];
    if (dpm[i]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic load(input int v, output int n);
    @(negedge sys_clk);
    num = 16'(v);
    num_valid = 1'b1;
    @(negedge sys_clk);
    num_valid = 1'b0;
    n = 0;
    while (busy5 && n < 200) begin
      n++;
      @(negedge sys_clk);
    end
  endtask

  // Records each digit's pattern once its select has been stable for a cycle
  task automatic capture(output logic [7:0] l5 [5], output logic [7:0] l4 [4], output bit ok);
    logic [4:0] p5;
    logic [3:0] p4;
    int s5 = 0, s4 = 0;
    bit bad = 0;
    p5 = 'x;
    p4 = 'x;
    for (int c = 0; c < 200 && !(s5 == 31 && s4 == 15); c++) begin
      @(negedge sys_clk);
      for (int k = 0; k < 5; k++)
        if (sel5 === (5'h1F ^ (5'd1 << k)) && sel5 === p5) begin l5[k] = led5; s5 |= 1 << k; end
      for (int k = 0; k < 4; k++)
        if (sel4 === (4'hF ^ (4'd1 << k)) && sel4 === p4) begin l4[k] = led4; s4 |= 1 << k; end
      if ($countones(~sel5) != 1 || $countones(~sel4) != 1) bad = 1;
      p5 = sel5;
      p4 = sel4;
    end
    ok = s5 == 31 && s4 == 15 && !bad;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy5); end
    checks++; if (led5 !== 8'hFF) begin errors++; $display("FAIL reset_led5 got %h want ff", led5); end
    checks++; if (sel5 !== 5'b11110) begin errors++; $display("FAIL reset_sel5 got %b want 11110", sel5); end
    checks++; if (led4 !== 8'hFF) begin errors++; $display("FAIL reset_led4 got %h want ff", led4); end
    checks++; if (sel4 !== 4'b1110) begin errors++; $display("FAIL reset_sel4 got %b want 1110", sel4); end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    bit ok;
    int n;
    blank_lz = 0; dp5 = '0; dp4 = '0;
    load(12345, n);
    checks++; if (n != 17) begin errors++; $display("FAIL basic_busy_cycles got %0d want 17", n); end
    capture(l5, l4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_scan got incomplete/bad select want all digits"); end
    for (int i = 0; i < 5; i++) begin
      e = exp_led(12345, 5, 0, 8'h00, i);
      checks++; if (l5[i] !== e) begin errors++; $display("FAIL basic_d5_%0d got %h want %h", i, l5[i], e); end
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_led(12345, 4, 0, 8'h00, i);
      checks++; if (l4[i] !== e) begin errors++; $display("FAIL basic_d4_%0d got %h want %h", i, l4[i], e); end
    end
  endtask

  task automatic test_blanking;
    int vals [3] = '{42, 42, 0};
    bit lzs [3] = '{1, 0, 1};
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    bit ok;
    int n;
    dp5 = '0; dp4 = '0;
    for (int t = 0; t < 3; t++) begin
      blank_lz = lzs[t];
      load(vals[t], n);
      capture(l5, l4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL blank_scan_%0d got incomplete/bad select want all digits", t); end
      for (int i = 0; i < 5; i++) begin
        e = exp_led(vals[t], 5, lzs[t], 8'h00, i);
        checks++; if (l5[i] !== e) begin errors++; $display("FAIL blank%0d_d5_%0d got %h want %h", t, i, l5[i], e); end
      end
      for (int i = 0; i < 4; i++) begin
        e = exp_led(vals[t], 4, lzs[t], 8'h00, i);
        checks++; if (l4[i] !== e) begin errors++; $display("FAIL blank%0d_d4_%0d got %h want %h", t, i, l4[i], e); end
      end
    end
  endtask

  task automatic test_overflow;
    int vals [3] = '{10000, 9999, 65535};
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    bit ok;
    int n;
    for (int t = 0; t < 3; t++) begin
      blank_lz = (t == 0);
      dp5 = 5'($urandom);
      dp4 = 4'($urandom);
      load(vals[t], n);
      capture(l5, l4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_scan_%0d got incomplete/bad select want all digits", t); end
      for (int i = 0; i < 5; i++) begin
        e = exp_led(vals[t], 5, blank_lz, {3'b0, dp5}, i);
        checks++; if (l5[i] !== e) begin errors++; $display("FAIL ovf%0d_d5_%0d got %h want %h", t, i, l5[i], e); end
      end
      for (int i = 0; i < 4; i++) begin
        e = exp_led(vals[t], 4, blank_lz, {4'b0, dp4}, i);
        checks++; if (l4[i] !== e) begin errors++; $display("FAIL ovf%0d_d4_%0d got %h want %h", t, i, l4[i], e); end
      end
    end
    dp5 = '0; dp4 = '0;
    load(9999, n);
  endtask

  task automatic test_back_to_back;
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    logic [4:0] p;
    bit ok, saw300 = 0;
    int n = 0;
    blank_lz = 0; dp5 = '0; dp4 = '0;
    p = 'x;
    @(negedge sys_clk);
    num = 16'd7;
    num_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge sys_clk);
      if (!busy5) break;
      n++;
      if (sel5 === p && sel5 === 5'b01111 && led5 === 8'hC0) saw300 = 1;
      p = sel5;
      num_valid = (c == 4 || c == 5);
      num = c == 4 ? 16'd300 : c == 5 ? 16'd301 : num;
    end
    num_valid = 1'b0;
    checks++; if (n != 34) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 34", n); end
    checks++; if (saw300) begin errors++; $display("FAIL b2b_shown_300 got shown want never"); end
    capture(l5, l4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_scan got incomplete/bad select want all digits"); end
    for (int i = 0; i < 5; i++) begin
      e = exp_led(301, 5, 0, 8'h00, i);
      checks++; if (l5[i] !== e) begin errors++; $display("FAIL b2b_d5_%0d got %h want %h", i, l5[i], e); end
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_led(301, 4, 0, 8'h00, i);
      checks++; if (l4[i] !== e) begin errors++; $display("FAIL b2b_d4_%0d got %h want %h", i, l4[i], e); end
    end
  endtask

  task automatic test_random;
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    bit ok;
    int n, v;
    for (int t = 0; t < 8; t++) begin
      v = t[0] ? int'($urandom_range(0, 65535)) : t[1] ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 120));
      blank_lz = 1'($urandom);
      dp5 = 5'($urandom);
      dp4 = 4'($urandom);
      load(v, n);
      checks++; if (n != 17) begin errors++; $display("FAIL rand%0d_busy_cycles got %0d want 17", t, n); end
      capture(l5, l4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_scan got incomplete/bad select want all digits", t); end
      for (int i = 0; i < 5; i++) begin
        e = exp_led(v, 5, blank_lz, {3'b0, dp5}, i);
        checks++; if (l5[i] !== e) begin errors++; $display("FAIL rand%0d_v%0d_d5_%0d got %h want %h", t, v, i, l5[i], e); end
      end
      for (int i = 0; i < 4; i++) begin
        e = exp_led(v, 4, blank_lz, {4'b0, dp4}, i);
        checks++; if (l4[i] !== e) begin errors++; $display("FAIL rand%0d_v%0d_d4_%0d got %h want %h", t, v, i, l4[i], e); end
      end
    end
  endtask

  task automatic test_blink;
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    logic [4:0] p, pp;
    bit off [12];
    bit ok, dp_seen = 0;
    int n, ns = 0, bad_vis = 0, noff = 0, k;
    blank_lz = 0; dp5 = 5'b00100; dp4 = '0;
    load(12345, n);
    blink_en = 1'b1;
    p = 'x;
    pp = 'x;
    for (int c = 0; c < 400 && ns < 12; c++) begin
      @(negedge sys_clk);
      if (sel5 === p && p !== pp) begin
        k = -1;
        for (int j = 0; j < 5; j++) if (sel5 === (5'h1F ^ (5'd1 << j))) k = j;
        off[ns] = led5 === 8'hFF;
        if (k < 0) bad_vis++;
        else if (!off[ns]) begin
          if (led5 !== exp_led(12345, 5, 0, 8'h04, k)) bad_vis++;
          if (k == 2 && led5[7] === 1'b0) dp_seen = 1;
        end
        ns++;
      end
      pp = p;
      p = sel5;
    end
    checks++; if (ns != 12) begin errors++; $display("FAIL blink_slots got %0d want 12", ns); end
    checks++; if (bad_vis != 0) begin errors++; $display("FAIL blink_visible_pattern got %0d bad slots want 0", bad_vis); end
    checks++; if (!dp_seen) begin errors++; $display("FAIL blink_dp2 got unseen want bit7=0 on digit 2"); end
    for (int j = 0; j < 12; j++) noff += off[j];
    checks++; if (noff != 6) begin errors++; $display("FAIL blink_off_slots got %0d want 6", noff); end
    for (int j = 0; j < 10; j++) begin
      checks++; if (off[j] == off[j+2]) begin errors++; $display("FAIL blink_period_%0d got slot %0d equal to slot %0d want opposite", j, j, j + 2); end
    end
    blink_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    capture(l5, l4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL unblink_scan got incomplete/bad select want all digits"); end
    for (int i = 0; i < 5; i++) begin
      e = exp_led(12345, 5, 0, 8'h04, i);
      checks++; if (l5[i] !== e) begin errors++; $display("FAIL unblink_d5_%0d got %h want %h", i, l5[i], e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] l5 [5];
    logic [7:0] l4 [4];
    logic [7:0] e;
    bit ok;
    blank_lz = 0; dp5 = '0; dp4 = '0;
    @(negedge sys_clk);
    num = 16'd54321;
    num_valid = 1'b1;
    @(negedge sys_clk);
    num_valid = 1'b0;
    @(negedge sys_clk);
    num = 16'd999;
    num_valid = 1'b1;
    @(negedge sys_clk);
    num_valid = 1'b0;
    repeat (6) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy5); end
    checks++; if (led5 !== 8'hFF) begin errors++; $display("FAIL rstmid_led5 got %h want ff", led5); end
    checks++; if (sel5 !== 5'b11110) begin errors++; $display("FAIL rstmid_sel5 got %b want 11110", sel5); end
    checks++; if (sel4 !== 4'b1110) begin errors++; $display("FAIL rstmid_sel4 got %b want 1110", sel4); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL rstmid_after_busy got %b want 0", busy5); end
    capture(l5, l4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_scan got incomplete/bad select want all digits"); end
    for (int i = 0; i < 5; i++) begin
      e = exp_led(0, 5, 0, 8'h00, i);
      checks++; if (l5[i] !== e) begin errors++; $display("FAIL rstmid_d5_%0d got %h want %h", i, l5[i], e); end
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_led(0, 4, 0, 8'h00, i);
      checks++; if (l4[i] !== e) begin errors++; $display("FAIL rstmid_d4_%0d got %h want %h", i, l4[i], e); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_blanking;
    test_overflow;
    test_back_to_back;
    test_random;
    test_blink;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed 7-segment driver. It is the successor to the fixed 5-digit scanner.
- Converts a binary value to BCD sequentially (double-dabble, one bit per clock) instead of using combinational divide/modulo.
- Adds leading-zero blanking, per-digit decimal points, whole-display blink and overflow indication.
- Sits between measurement/learning logic (frequency, amplitude results) and the board's digit/segment pins.

Parameters:
- DIGITS, 5, number of digits scanned (2..8).
- DATA_W, 16, width of the binary input value.
- SCAN_DIV, 50000, sys_clk cycles per digit slot.
- BLINK_TICKS, 250, scan-slot wraps per blink half-period.
- SEG_ACTIVE_LOW, 1, 1 = seg_led driven low-active.
- SEL_ACTIVE_LOW, 1, 1 = seg_sel driven low-active.

Ports:
- sys_clk  in  1  system clock, single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- num  in  DATA_W  binary value to display.
- num_valid  in  1  one-cycle load strobe for num.
- busy  out  1  conversion in progress.
- dp_mask  in  DIGITS  bit i lights the decimal point of digit i (digit 0 = most significant).
- blank_lz  in  1  enable leading-zero blanking.
- blink_en  in  1  enable whole-display blink.
- seg_sel  out  DIGITS  one-hot digit select.
- seg_led  out  8  segments {dp,g,f,e,d,c,b,a}.

Behaviour:
Clock and reset
- One clock, sys_clk. Reset sys_rst_n is asynchronous, active-low.

Reset values
- busy = 0.
- Display register = all digits 0, overflow flag = 0.
- seg_sel selects digit 0, e.g. 5'b11110 for DIGITS=5, SEL_ACTIVE_LOW=1.
- seg_led = all segments off (8'hFF when SEG_ACTIVE_LOW=1).
- Scan counter, digit index, blink counter and blink phase = 0 (phase 0 = on).

Conversion FSM (IDLE, SHIFT, COMMIT)
- IDLE: num_valid=1 latches num into the shift register, clears the BCD register and the overflow flag, sets busy, moves to SHIFT.
- SHIFT: exactly DATA_W cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1.
  - If the bit shifted out of the top nibble is 1, set overflow (value >= 10^DIGITS).
- COMMIT: one cycle. Copy the BCD register and overflow flag to the display register, clear busy, return to IDLE.
- Latency: strobe at edge 0 -> new digits visible in the display register after edge DATA_W+1. busy is high for DATA_W+1 cycles.
- num_valid while busy: the value goes into a one-deep pending register (last write wins). On COMMIT with pending set, go directly to SHIFT with the pending value. busy stays high throughout.
- The display register changes only in COMMIT; a partial conversion is never shown.

Scan
- Counter runs 0..SCAN_DIV-1.
- On wrap, the digit index advances 0..DIGITS-1 and wraps to 0; seg_sel updates on the same edge.
- seg_led is registered: it follows the index with 1 cycle of latency and never shows one digit's pattern with another digit's select for more than that cycle.

Digit pattern priority
1. Blink phase off (blink_en=1) -> blank, including dp.
2. Overflow -> dash (segment g only) on every digit; leading-zero blanking is ignored.
3. blank_lz=1 and digit is above the most significant nonzero digit -> blank. The last digit (DIGITS-1) is never blanked, so 0 shows as "0".
4. Otherwise -> decimal glyph 0..9; BCD values > 9 are impossible by construction and show blank.
- dp is ORed in from dp_mask[index] unless rule 1 applies.

Blink
- Blink counter counts scan wraps. Every BLINK_TICKS wraps it toggles the phase.
- blink_en=0 forces phase on and holds the counter at 0.

Polarity
- Patterns are held active-high internally and inverted at the output register per SEG_ACTIVE_LOW / SEL_ACTIVE_LOW.

Reset mid-conversion
- The conversion is abandoned; all state returns to reset values and the pending value is discarded.

Decomposition:
- Package seg_pkg:
  - 7-segment glyph constants 0..9, BLANK, DASH (active-high).
  - Conversion FSM state encoding.
  - Function ceil_log2 for index width.
- Sub-module bin2bcd_seq (parameters DATA_W, DIGITS):
  - Ports start/busy/done, bcd out, ovf out.
  - Holds the double-dabble FSM.
  - The top level keeps scan, blink, blanking and the output registers.

Test Plan:
Bench parameters: SCAN_DIV=4, BLINK_TICKS=2, both polarities active-low unless noted.
1. Reset, then num=12345 with num_valid=1 for 1 cycle -> busy high 17 cycles. Over the next 5 slots seg_led = F9,A4,B0,99,92 with seg_sel 11110,11101,11011,10111,01111.
2. num=42, blank_lz=1 -> digits 0..2 = FF, digits 3..4 = 99,A4. With blank_lz=0 -> C0,C0,C0,99,A4. num=0, blank_lz=1 -> FF,FF,FF,FF,C0.
3. DIGITS=4, num=10000 -> overflow; all four digits BF. num=9999 -> 90 on all digits.
4. num_valid at edge 0 (value 7), then again at edge 5 (value 300) and edge 6 (value 301) -> display shows 7, then 301 at edge 34. 300 is never displayed; busy stays high continuously.
5. blink_en=1, dp_mask=5'b00100 -> digit 2 shows dp cleared (bit7=0). All digits FF for 2 slot-wraps, then visible for 2, repeating.
6. Assert sys_rst_n=0 at SHIFT cycle 8 -> busy=0, seg_led=FF and seg_sel selects digit 0 immediately (asynchronous). The old value is not shown after release until a new strobe.
